// File: rtl/xor_struct.sv
// rtl/xor_struct.sv - NAND-built bitwise XOR with registered copy, accumulator, parity and toggle counter

module xor_struct_nand2 (
    input  logic x,
    input  logic y,
    output logic z
);
    nand g0 (z, x, y);
endmodule

module xor_struct #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] acc,
    output logic             par,
    output logic [15:0]      tgl_cnt
);
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic [WIDTH-1:0] n3;

    // Classic four-NAND XOR per bit so the o path carries no clock or reset.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor_struct_nand2 u_n1 (.x(a[i]),  .y(b[i]),  .z(n1[i]));
        xor_struct_nand2 u_n2 (.x(a[i]),  .y(n1[i]), .z(n2[i]));
        xor_struct_nand2 u_n3 (.x(b[i]),  .y(n1[i]), .z(n3[i]));
        xor_struct_nand2 u_n4 (.x(n2[i]), .y(n3[i]), .z(o[i]));
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [15:0]      tgl_cnt_q, tgl_cnt_d;

    always_comb begin
        out_d     = out_q;
        acc_d     = acc_q;
        tgl_cnt_d = tgl_cnt_q;
        if (en) begin
            out_d = o;
            acc_d = acc_q ^ o;
            if ((o != out_q) && (tgl_cnt_q != 16'hFFFF)) begin
                tgl_cnt_d = tgl_cnt_q + 16'd1;
            end
        end
        // Clear wins over enable for the accumulator and counter only.
        if (clr) begin
            acc_d     = '0;
            tgl_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            acc_q     <= '0;
            tgl_cnt_q <= '0;
        end else begin
            out_q     <= out_d;
            acc_q     <= acc_d;
            tgl_cnt_q <= tgl_cnt_d;
        end
    end

    assign o_q     = out_q;
    assign acc     = acc_q;
    assign par     = ^out_q;
    assign tgl_cnt = tgl_cnt_q;
endmodule

// File: tb/tb_xor_struct.sv
// tb/tb_xor_struct.sv - directed self-checking bench for xor_struct at WIDTH=1 and WIDTH=8

module tb_xor_struct;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, en1, clr1;
    logic [0:0]  a1, b1, o1, oq1, acc1;
    logic        par1;
    logic [15:0] tgl1;

    logic        rst8, en8, clr8;
    logic [7:0]  a8, b8, o8, oq8, acc8;
    logic        par8;
    logic [15:0] tgl8;

    int checks = 0;
    int failures = 0;

    xor_struct #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst1), .a(a1), .b(b1), .en(en1), .clr(clr1),
        .o(o1), .o_q(oq1), .acc(acc1), .par(par1), .tgl_cnt(tgl1)
    );

    xor_struct #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8), .a(a8), .b(b8), .en(en8), .clr(clr8),
        .o(o8), .o_q(oq8), .acc(acc8), .par(par8), .tgl_cnt(tgl8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge8();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b0; en1 = 1'b0; clr1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        rst8 = 1'b0; en8 = 1'b0; clr8 = 1'b0; a8 = 8'hF0; b8 = 8'h3C;

        // WIDTH=1 truth table walk with en=0, sampled 1 ns after each change.
        #1;
        check("w1_o_t1", o1, 1'b0);
        check("rst_oq", oq8, 8'h00);
        check("rst_acc", acc8, 8'h00);
        check("rst_tgl", tgl8, 16'h0);
        check("rst_par", par8, 1'b0);
        check("rst_o_live", o8, 8'hCC);
        #9 a1 = 1'b1;
        #1 check("w1_o_t11", o1, 1'b1);
        #9 a1 = 1'b0; b1 = 1'b1;
        #1 check("w1_o_t21", o1, 1'b1);
        #9 a1 = 1'b1;
        #1 check("w1_o_t31", o1, 1'b0);
        check("w1_oq_hold", oq1, 1'b0);
        check("w1_par", par1, 1'b0);
        rst1 = 1'b1; rst8 = 1'b1;
        @(negedge clk);

        // Single enabled capture of F0^3C.
        en8 = 1'b1;
        #1 check("o_cc_immediate", o8, 8'hCC);
        edge8();
        check("cap_oq", oq8, 8'hCC);
        check("cap_par", par8, 1'b0);
        check("cap_acc", acc8, 8'hCC);
        check("cap_tgl", tgl8, 16'd1);

        // en=0 holds everything even though o differs.
        en8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
        edge8();
        check("hold_oq", oq8, 8'hCC);
        check("hold_acc", acc8, 8'hCC);
        check("hold_tgl", tgl8, 16'd1);

        // Build acc=5A, then async reset between edges.
        en8 = 1'b1; a8 = 8'h96; b8 = 8'h00;
        edge8();
        check("pre_rst_acc", acc8, 8'h5A);
        check("pre_rst_tgl", tgl8, 16'd2);
        #2 rst8 = 1'b0;
        #1;
        check("async_acc", acc8, 8'h00);
        check("async_oq", oq8, 8'h00);
        check("async_tgl", tgl8, 16'h0);
        check("async_o_live", o8, 8'h96);
        @(negedge clk);
        rst8 = 1'b1;

        // 01, 01, 02 sequence from reset.
        a8 = 8'h01; b8 = 8'h00;
        edge8();
        check("seq1_acc", acc8, 8'h01);
        check("seq1_tgl", tgl8, 16'd1);
        edge8();
        check("seq2_acc", acc8, 8'h00);
        check("seq2_tgl", tgl8, 16'd1);
        a8 = 8'h03; b8 = 8'h01;
        edge8();
        check("seq3_acc", acc8, 8'h02);
        check("seq3_tgl", tgl8, 16'd2);
        check("seq3_par", par8, 1'b1);

        // clr together with en.
        clr8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        edge8();
        check("clr_en_acc", acc8, 8'h00);
        check("clr_en_tgl", tgl8, 16'h0);
        check("clr_en_oq", oq8, 8'hFF);
        check("clr_en_par", par8, 1'b0);

        // clr with en=0 still clears, o_q holds.
        clr8 = 1'b0; a8 = 8'h0F;
        edge8();
        check("pre_clr_acc", acc8, 8'h0F);
        en8 = 1'b0; clr8 = 1'b1; a8 = 8'hF0;
        edge8();
        check("clr_noen_acc", acc8, 8'h00);
        check("clr_noen_tgl", tgl8, 16'h0);
        check("clr_noen_oq", oq8, 8'h0F);
        clr8 = 1'b0;

        // Saturation of the toggle counter.
        force dut8.tgl_cnt_q = 16'hFFFF;
        #1 release dut8.tgl_cnt_q;
        #1 check("sat_forced", tgl8, 16'hFFFF);
        en8 = 1'b1; a8 = 8'h55; b8 = 8'h00;
        edge8();
        check("sat_hold", tgl8, 16'hFFFF);
        check("sat_oq", oq8, 8'h55);
        check("sat_par", par8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xor_struct.md
XOR_STRUCT -- requirements
Module: xor_struct

Interface
REQ-001 Parameter WIDTH, default 1, sets the bit width of the data operands; legal range 1..64.
REQ-002 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 Port a, input, WIDTH, operand A.
REQ-005 Port b, input, WIDTH, operand B.
REQ-006 Port en, input, 1, capture enable for registered outputs and accumulator.
REQ-007 Port clr, input, 1, synchronous clear of accumulator and toggle counter.
REQ-008 Port o, output, WIDTH, combinational bitwise a XOR b.
REQ-009 Port o_q, output, WIDTH, registered copy of o.
REQ-010 Port acc, output, WIDTH, running XOR accumulation of o.
REQ-011 Port par, output, 1, reduction XOR (odd parity) of o_q.
REQ-012 Port tgl_cnt, output, 16, count of enabled cycles where o differs from o_q.

Function
REQ-013 o SHALL be purely combinational, no clock or reset dependence; o[i] = a[i] XOR b[i] for every i.
REQ-014 Each o bit SHALL be built structurally from four 2-input NAND gate instances (n1=NAND(a,b), n2=NAND(a,n1), n3=NAND(b,n1), o=NAND(n2,n3)); no behavioural XOR operator on the o path.
REQ-015 o SHALL settle with zero simulation delay: any change on a or b is visible on o in the same time step, well under 1 ns.
REQ-016 Truth table per bit: 00->0, 10->1, 01->1, 11->0.
REQ-017 On rising clk with en=1: o_q <= o; acc <= acc XOR o; tgl_cnt <= tgl_cnt+1 if o != o_q, else hold.
REQ-018 On rising clk with en=0: o_q, acc, tgl_cnt SHALL hold.
REQ-019 clr=1 at rising clk SHALL set acc=0 and tgl_cnt=0, overriding en for those two registers; o_q still follows REQ-017/018.
REQ-020 tgl_cnt SHALL saturate at 16'hFFFF (no wrap).
REQ-021 par SHALL be combinational from o_q (XOR of all o_q bits); for WIDTH=1, par = o_q.
REQ-022 Registered outputs update with one-cycle latency from the en-qualified capture edge; o has zero latency.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force o_q=0, acc=0, tgl_cnt=0, hence par=0.
REQ-024 o SHALL remain a live function of a and b during reset.
REQ-025 Reset asserted mid-operation SHALL discard all state; first capture after rst_n deassertion behaves as from power-up.
REQ-026 rst_n deassertion is synchronised externally; no internal synchroniser is required.

Verification
REQ-027 WIDTH=1, en=0: a toggles every 10 ns, b every 20 ns from 00; sample 1 ns after each change -> o = 0,1,1,0 at t=1,11,21,31 ns.
REQ-028 WIDTH=8, a=8'hF0, b=8'h3C -> o=8'hCC immediately; after one en=1 edge o_q=8'hCC, par=0.
REQ-029 From reset, en=1, o sequence 8'h01, 8'h01, 8'h02 on three edges -> acc=8'h02, tgl_cnt=2.
REQ-030 rst_n pulled low between clock edges with acc=8'h5A -> acc=0, o_q=0, tgl_cnt=0 before next edge; o still = a XOR b.
REQ-031 clr=1 and en=1 on the same edge with o=8'hFF -> acc=0, tgl_cnt=0, o_q=8'hFF.
REQ-032 Force tgl_cnt to 16'hFFFF, then an enabled edge with o != o_q -> tgl_cnt stays 16'hFFFF.
